seq_mul_core: RTL and testbench

- Sequential unsigned multiplier using repeated addition. Computes product = A * B by adding A into an accumulator B times, decrementing a B counter each step.
- A control FSM and a register/adder datapath are combined in one block.
- Standalone arithmetic leaf. Driven by a start pulse or level; reports completion with a one-cycle done strobe.

---
 rtl/seq_mul_pkg.sv | 17 +
 rtl/seq_mul_datapath.sv | 53 +++++
 rtl/seq_mul_core.sv | 91 +++++++++
 tb/tb_seq_mul_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential repeated-addition multiplier:
//   DEFAULT_WIDTH    - default operand width in bits (product is 2x this)
//   seq_mul_state_t  - control FSM state encoding
// -----------------------------------------------------------------------------
package seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } seq_mul_state_t;

endpackage : seq_mul_pkg

// File: rtl/seq_mul_datapath.sv
// -----------------------------------------------------------------------------
// seq_mul_datapath
// Operand registers, product accumulator, adder, down-counter and zero flag.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (clears all registers)
//   load     in   capture a/b and clear the product
//   acc_en   in   accumulate one step (only takes effect while zero=0)
//   a        in   [WIDTH-1:0]   multiplicand
//   b        in   [WIDTH-1:0]   multiplier / iteration count
//   product  out  [2*WIDTH-1:0] accumulator, held between operations
//   zero     out  remaining iteration count is zero
// -----------------------------------------------------------------------------
module seq_mul_datapath
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               acc_en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               zero
);

    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;

    assign zero = (reg_b == '0);

    // NOTE: registered state is always written with non-blocking (<=) so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a   <= '0;
            reg_b   <= '0;
            product <= '0;
        end else if (load) begin
            reg_a   <= a;
            reg_b   <= b;
            product <= '0;
        end else if (acc_en && !zero) begin
            // Gating on !zero keeps the down-counter from ever wrapping.
            product <= product + {{WIDTH{1'b0}}, reg_a};
            reg_b   <= reg_b - WIDTH'(1);
        end
    end

endmodule : seq_mul_datapath

// File: rtl/seq_mul_core.sv
// -----------------------------------------------------------------------------
// seq_mul_core
// Sequential unsigned multiplier: product = a * b by adding a into an
// accumulator b times. Operands are latched when start is seen in IDLE; the
// result is flagged by a one-cycle done strobe and held until the next load.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (aborts any operation)
//   start    in   request a multiply; only looked at in IDLE
//   a        in   [WIDTH-1:0]   multiplicand
//   b        in   [WIDTH-1:0]   multiplier (iteration count)
//   product  out  [2*WIDTH-1:0] result, valid while done=1
//   done     out  one-cycle completion strobe
//   busy     out  high while accumulating
// -----------------------------------------------------------------------------
module seq_mul_core
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done,
    output logic               busy
);

    seq_mul_state_t state_q;
    seq_mul_state_t state_d;
    logic           load;
    logic           acc_en;
    logic           zero;

    seq_mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .acc_en  (acc_en),
        .a       (a),
        .b       (b),
        .product (product),
        .zero    (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_en = 1'b1;
                if (zero) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded straight from the state register.
    assign done = (state_q == S_DONE);
    assign busy = (state_q == S_ACC);

endmodule : seq_mul_core

// File: tb/tb_seq_mul_core.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_core
// Scoreboard bench for seq_mul_core (WIDTH=2). The stimulus process pushes the
// expected product and the edge count at which done must appear; a monitor
// pops and compares every time the DUT raises done.
// -----------------------------------------------------------------------------
module tb_seq_mul_core;

    localparam int WIDTH = 2;

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int unsigned        done_at;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [2*WIDTH-1:0] product;
    logic               done;
    logic               busy;

    exp_t        sb[$];
    int unsigned edges = 0;
    int          tests = 0;
    int          fails = 0;
    logic        prev_done = 1'b0;

    seq_mul_core #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whenever the DUT presents done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_low_in_done", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", {28'd0, product}, {28'd0, e.prod});
                    check("latency_edge", edges, e.done_at);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one start pulse at a negedge; lat counts the sampling edge as 1.
    task automatic do_op(input int av, input int bv, input int exp_prod, input int lat);
        exp_t e;
        a     = WIDTH'(av);
        b     = WIDTH'(bv);
        start = 1'b1;
        e.prod    = 4'(exp_prod);
        e.done_at = edges + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for all expected results, then one more cycle so the DUT is in IDLE.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_product", {28'd0, product}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 3*2 = 6, done on the 4th edge; result held afterwards
        do_op(3, 2, 6, 4);
        drain("op_3x2");
        @(negedge clk);
        check("hold_product", {28'd0, product}, 32'd6);

        // 3*3 = 9 with operand changes and a stray start while busy
        do_op(3, 3, 9, 5);
        a = 2'd1;
        b = 2'd1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("op_3x3");

        // Zero operands
        do_op(2, 0, 0, 2);
        drain("op_2x0");
        do_op(0, 3, 0, 5);
        drain("op_0x3");

        // start held high: repeating every 5 edges; a changed mid-operation
        begin
            exp_t e;
            int unsigned base;
            base  = edges;
            a     = 2'd3;
            b     = 2'd2;
            start = 1'b1;
            e.prod = 4'd6; e.done_at = base + 4;  sb.push_back(e);
            e.prod = 4'd2; e.done_at = base + 9;  sb.push_back(e);
            e.prod = 4'd2; e.done_at = base + 14; sb.push_back(e);
            repeat (2) @(negedge clk);
            a = 2'd1;
            repeat (12) @(negedge clk);
            start = 1'b0;
            drain("held_start");
        end

        // Asynchronous reset in the middle of ACC
        a     = 2'd3;
        b     = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_product", {28'd0, product}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(3, 3, 9, 5);
        drain("after_abort");

        // Full sweep: product a*b, latency b+2
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                do_op(i, j, i * j, j + 2);
                drain("sweep");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_seq_mul_core
